pipe_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage core. Merges ID load-use stalls, EX multi-cycle
//  ops (madd/msub, fixed latency) and divider handshakes into one per-stage stall vector that gates
//  pc/if_id/id_ex/ex_mem/mem_wb. Issues a one-cycle pipeline flush on exception request.

---
 rtl/pipe_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- pipeline sequencing controller for the 5-stage core.
//
// Merges the ID load-use hold, the EX fixed-latency multi-cycle hold and the
// divider handshake into a single per-stage stall vector. It also issues a
// one-cycle flush on an exception request and owns divider start/cancel plus a
// divider watchdog.
//
// Parameters
//   MC_CYCLES    total EX cycles of a fixed-latency multi-cycle op (>= 2)
//   DIV_TIMEOUT  max DIV_WAIT cycles before the divider is aborted (>= 2)
//
// Ports
//   clk          in   clock, all state updates on posedge
//   rst          in   synchronous active-high reset
//   stallreq_id  in   ID load-use hold request
//   ex_mc_req    in   EX holds a fixed-latency multi-cycle op (first cycle)
//   div_req      in   EX holds a div/divu needing a result
//   div_ready    in   divider result valid this cycle
//   flush_req    in   exception/flush request from MEM
//   stall[5:0]   out  [0]pc [1]if [2]id [3]ex [4]mem [5]wb, 1 = hold stage
//   flush        out  clear all pipeline registers this cycle
//   div_start    out  one-cycle divider launch pulse
//   div_cancel   out  one-cycle divider abort pulse
//   div_err      out  one-cycle pulse, divider watchdog expired
//   busy         out  controller is not in RUN
//
// Outputs are combinational from state, counter and inputs so that a hazard
// seen by a stage holds that same cycle. All outputs read 0 during reset.
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int MC_CYCLES   = 2,
  parameter int DIV_TIMEOUT = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stallreq_id,
  input  logic       ex_mc_req,
  input  logic       div_req,
  input  logic       div_ready,
  input  logic       flush_req,
  output logic [5:0] stall,
  output logic       flush,
  output logic       div_start,
  output logic       div_cancel,
  output logic       div_err,
  output logic       busy
);

  localparam int CNT_MAX = (MC_CYCLES > DIV_TIMEOUT) ? MC_CYCLES : DIV_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [5:0]       STALL_EX   = 6'b001111;
  localparam logic [5:0]       STALL_ID   = 6'b000111;
  localparam logic [5:0]       STALL_NONE = 6'b000000;
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] MC_INIT    = CNT_W'(MC_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_WAIT  = 2'd1,
    DIV_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [5:0]       stall_s;
  logic             flush_s;
  logic             start_s;
  logic             cancel_s;
  logic             err_s;

  // State and counter register; reset drops straight to RUN with no cancel
  // pulse because the divider is reset by the same rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RUN;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state, counter update and raw (pre-reset-gating) outputs.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    stall_s     = STALL_NONE;
    flush_s     = 1'b0;
    start_s     = 1'b0;
    cancel_s    = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      RUN: begin
        if (flush_req) begin
          state_nxt_s = FLUSH;
        end else if (div_req) begin
          // div_req beats ex_mc_req if EX ever raises both.
          start_s     = 1'b1;
          stall_s     = STALL_EX;
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = DIV_WAIT;
        end else if (ex_mc_req) begin
          stall_s = STALL_EX;
          // A two-cycle op needs only this one held cycle.
          if (MC_CYCLES > 2) begin
            cnt_nxt_s   = MC_INIT;
            state_nxt_s = MC_WAIT;
          end else begin
            state_nxt_s = RUN;
          end
        end else if (stallreq_id) begin
          stall_s = STALL_ID;
        end else begin
          stall_s = STALL_NONE;
        end
      end
      MC_WAIT: begin
        if (flush_req) begin
          state_nxt_s = FLUSH;
        end else begin
          stall_s   = STALL_EX;
          cnt_nxt_s = cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = MC_WAIT;
          end
        end
      end
      DIV_WAIT: begin
        cnt_nxt_s = cnt_r + CNT_ONE;
        if (flush_req) begin
          cancel_s    = 1'b1;
          state_nxt_s = FLUSH;
        end else if (div_ready) begin
          // Result is captured by EX this cycle, so the pipe advances.
          state_nxt_s = RUN;
        end else if (cnt_r == DIV_LAST) begin
          cancel_s    = 1'b1;
          err_s       = 1'b1;
          state_nxt_s = RUN;
        end else begin
          stall_s = STALL_EX;
        end
      end
      FLUSH: begin
        flush_s     = 1'b1;
        state_nxt_s = RUN;
      end
      default: begin
        state_nxt_s = RUN;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Output gating: everything reads 0 while reset is asserted.
  always_comb begin
    if (rst) begin
      stall      = STALL_NONE;
      flush      = 1'b0;
      div_start  = 1'b0;
      div_cancel = 1'b0;
      div_err    = 1'b0;
      busy       = 1'b0;
    end else begin
      stall      = stall_s;
      flush      = flush_s;
      div_start  = start_s;
      div_cancel = cancel_s;
      div_err    = err_s;
      busy       = (state_r != RUN);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl (MC_CYCLES=3,
// DIV_TIMEOUT=40). A directed vector table, two hand-written divider watchdog
// sequences, then randomized traffic compared against a behavioural model.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int MC  = 3;
  localparam int DTO = 40;

  logic       clk = 1'b0;
  logic       rst, stallreq_id, ex_mc_req, div_req, div_ready, flush_req;
  logic [5:0] stall;
  logic       flush, div_start, div_cancel, div_err, busy;

  pipe_ctrl #(.MC_CYCLES(MC), .DIV_TIMEOUT(DTO)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_mc_req(ex_mc_req),
    .div_req(div_req), .div_ready(div_ready), .flush_req(flush_req),
    .stall(stall), .flush(flush), .div_start(div_start),
    .div_cancel(div_cancel), .div_err(div_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Output bundle {stall[5:0], flush, div_start, div_cancel, div_err, busy}
  localparam logic [5:0] SX = 6'b001111;
  localparam logic [5:0] SI = 6'b000111;
  localparam logic [5:0] S0 = 6'b000000;

  function automatic logic [10:0] o(input logic [5:0] st, input logic fl,
                                    input logic sa, input logic ca,
                                    input logic er, input logic bu);
    return {st, fl, sa, ca, er, bu};
  endfunction

  // Input bundle {rst, stallreq_id, ex_mc_req, div_req, div_ready, flush_req}
  function automatic logic [5:0] i(input logic r, input logic sid,
                                   input logic mc, input logic dq,
                                   input logic dr, input logic fq);
    return {r, sid, mc, dq, dr, fq};
  endfunction

  // ---------------- behavioural model ----------------
  // Tracks "what is outstanding" rather than controller states.
  bit m_flush_due = 1'b0;  // a flush cycle is owed next
  bit m_div_busy  = 1'b0;  // a divide is outstanding
  int m_div_age   = 0;     // cycles since the divide was launched
  int m_mc_left   = 0;     // extra EX hold cycles still owed

  task automatic model_step(input logic [5:0] ins, output logic [10:0] exp);
    logic r, sid, mc, dq, dr, fq;
    logic [5:0] st;
    logic fl, sa, ca, er, bu;
    {r, sid, mc, dq, dr, fq} = ins;
    st = S0; fl = 1'b0; sa = 1'b0; ca = 1'b0; er = 1'b0; bu = 1'b0;
    if (r) begin
      m_flush_due = 1'b0; m_div_busy = 1'b0; m_div_age = 0; m_mc_left = 0;
    end else if (m_flush_due) begin
      fl = 1'b1; bu = 1'b1; m_flush_due = 1'b0;
    end else if (m_div_busy) begin
      bu = 1'b1;
      if (fq) begin
        ca = 1'b1; m_div_busy = 1'b0; m_flush_due = 1'b1;
      end else if (dr) begin
        m_div_busy = 1'b0;
      end else if (m_div_age == DTO) begin
        ca = 1'b1; er = 1'b1; m_div_busy = 1'b0;
      end else begin
        st = SX; m_div_age++;
      end
    end else if (m_mc_left > 0) begin
      bu = 1'b1;
      if (fq) begin
        m_mc_left = 0; m_flush_due = 1'b1;
      end else begin
        st = SX; m_mc_left--;
      end
    end else begin
      if (fq) begin
        m_flush_due = 1'b1;
      end else if (dq) begin
        sa = 1'b1; st = SX; m_div_busy = 1'b1; m_div_age = 1;
      end else if (mc) begin
        st = SX; m_mc_left = MC - 2;
      end else if (sid) begin
        st = SI;
      end
    end
    exp = o(st, fl, sa, ca, er, bu);
  endtask

  // Drive one cycle, compare against exp (or the model when use_model=1).
  task automatic apply(input logic [5:0] ins, input logic [10:0] exp_in,
                       input bit use_model, input string name);
    logic [10:0] mexp, exp, got;
    @(negedge clk);
    {rst, stallreq_id, ex_mc_req, div_req, div_ready, flush_req} = ins;
    #1;
    model_step(ins, mexp);
    exp = use_model ? mexp : exp_in;
    got = {stall, flush, div_start, div_cancel, div_err, busy};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: in=%b got stall=%b fl=%b st=%b ca=%b er=%b bu=%b, want stall=%b fl=%b st=%b ca=%b er=%b bu=%b",
               name, ins, got[10:5], got[4], got[3], got[2], got[1], got[0],
               exp[10:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  typedef struct {
    logic [5:0]  ins;
    logic [10:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [5:0] ins, input logic [10:0] exp, input string name);
    vec_t v;
    v.ins = ins; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endtask

  initial begin
    logic [10:0] dummy;
    {rst, stallreq_id, ex_mc_req, div_req, div_ready, flush_req} = 6'b100000;
    dummy = 11'd0;

    // reset with every request high: outputs all 0
    add(i(1,1,1,1,1,1), o(S0,0,0,0,0,0), "rst_all_req0");
    add(i(1,1,1,1,1,1), o(S0,0,0,0,0,0), "rst_all_req1");
    add(i(1,1,1,1,1,1), o(S0,0,0,0,0,0), "rst_all_req2");
    add(i(0,0,0,0,0,0), o(S0,0,0,0,0,0), "post_rst_idle");
    // ID load-use hold
    add(i(0,1,0,0,0,0), o(SI,0,0,0,0,0), "id_hold0");
    add(i(0,1,0,0,0,0), o(SI,0,0,0,0,0), "id_hold1");
    add(i(0,0,0,0,0,0), o(S0,0,0,0,0,0), "id_release");
    // 3-cycle multi-cycle op: hold 2 cycles, busy only on the second
    add(i(0,0,1,0,0,0), o(SX,0,0,0,0,0), "mc_first");
    add(i(0,1,1,0,0,0), o(SX,0,0,0,0,1), "mc_wait");
    add(i(0,0,0,0,0,0), o(S0,0,0,0,0,0), "mc_done");
    // div_req with ex_mc_req: divider wins
    add(i(0,0,1,1,0,0), o(SX,0,1,0,0,0), "div_beats_mc");
    add(i(0,0,0,0,1,0), o(S0,0,0,0,0,1), "div_ready");
    add(i(0,0,0,0,0,0), o(S0,0,0,0,0,0), "div_back_run");
    // flush_req in RUN beats div_req; held flush_req pulses every 2nd cycle
    add(i(0,0,0,1,0,1), o(S0,0,0,0,0,0), "flush_beats_div");
    add(i(0,1,0,0,0,1), o(S0,1,0,0,0,1), "flush_cycle0");
    add(i(0,0,0,0,0,1), o(S0,0,0,0,0,0), "flush_reenter");
    add(i(0,0,0,0,0,0), o(S0,1,0,0,0,1), "flush_cycle1");
    add(i(0,0,0,0,0,0), o(S0,0,0,0,0,0), "flush_to_run");
    // flush during MC_WAIT
    add(i(0,0,1,0,0,0), o(SX,0,0,0,0,0), "mc_then_flush0");
    add(i(0,0,0,0,0,1), o(S0,0,0,0,0,1), "mc_flush");
    add(i(0,0,0,0,0,0), o(S0,1,0,0,0,1), "mc_flush_cycle");
    // flush during DIV_WAIT beats div_ready; ID hold ignored in FLUSH
    add(i(0,0,0,1,0,0), o(SX,0,1,0,0,0), "div_then_flush0");
    add(i(0,0,0,0,1,1), o(S0,0,0,1,0,1), "div_flush_cancel");
    add(i(0,1,0,0,0,0), o(S0,1,0,0,0,1), "div_flush_cycle");
    add(i(0,1,0,0,0,0), o(SI,0,0,0,0,0), "div_flush_run");
    // reset mid-divide: silent abort
    add(i(0,0,0,1,0,0), o(SX,0,1,0,0,0), "div_before_rst");
    add(i(1,0,0,0,0,0), o(S0,0,0,0,0,0), "rst_in_div");
    add(i(0,0,0,0,0,0), o(S0,0,0,0,0,0), "after_rst_div");

    foreach (tbl[k]) apply(tbl[k].ins, tbl[k].exp, 1'b0, tbl[k].name);

    // watchdog: launch at cycle 0, never ready, abort at cycle DTO
    apply(i(0,0,0,1,0,0), o(SX,0,1,0,0,0), 1'b0, "wd_launch");
    for (int c = 1; c < DTO; c++)
      apply(i(0,0,0,0,0,0), o(SX,0,0,0,0,1), 1'b0, "wd_wait");
    apply(i(0,0,0,0,0,0), o(S0,0,0,1,1,1), 1'b0, "wd_expire");
    apply(i(0,0,0,0,0,0), o(S0,0,0,0,0,0), 1'b0, "wd_after");

    // ready in the timeout cycle wins: no cancel, no error
    apply(i(0,0,0,1,0,0), o(SX,0,1,0,0,0), 1'b0, "wdr_launch");
    for (int c = 1; c < DTO; c++)
      apply(i(0,0,0,0,0,0), o(SX,0,0,0,0,1), 1'b0, "wdr_wait");
    apply(i(0,0,0,0,1,0), o(S0,0,0,0,0,1), 1'b0, "wdr_ready_wins");
    apply(i(0,0,0,0,0,0), o(S0,0,0,0,0,0), 1'b0, "wdr_after");

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      logic [5:0] ins;
      ins = i(($urandom_range(0, 99) < 2),  ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 5) == 0),  ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
      apply(ins, dummy, 1'b1, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
